// File: rtl/d0_fifo_reader_pkg.sv
// Shared definitions for the D0 transmit FIFO read-side controller.
// Holds FSM state encodings and default widths.
package d0_fifo_reader_pkg;

  localparam int D0_DATA_WIDTH     = 6;
  localparam int D0_BUF_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } d0_state_t;

endpackage

// File: rtl/d0_fifo_reader_if.sv
// Bundle of FIFO-side and downstream-side signals of the D0 FIFO reader.
// Downstream handshake: a word moves on a posedge where valid_out & ready_in;
// while ready_in = 0, valid_out/data_out hold; data_out is 0 whenever valid_out = 0.
interface d0_fifo_reader_if
  import d0_fifo_reader_pkg::*;
#(
  parameter int DW = D0_DATA_WIDTH
) ();

  logic          enable;
  logic          fifo_empty;
  logic          fifo_error;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_enable;
  logic          pause;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          error_out;
  logic [7:0]    word_cnt;
  d0_state_t     state;

  modport master (
    input  enable, fifo_empty, fifo_error, fifo_data_out, pause, ready_in,
    output fifo_rd_enable, valid_out, data_out, busy, error_out, word_cnt, state
  );

  modport slave (
    output enable, fifo_empty, fifo_error, fifo_data_out, pause, ready_in,
    input  fifo_rd_enable, valid_out, data_out, busy, error_out, word_cnt, state
  );

endinterface

// File: rtl/d0_reader_buf.sv
// Small circular output buffer: captured FIFO words queue here until the
// downstream stage accepts them. Head is forced to 0 while empty.
module d0_reader_buf
  import d0_fifo_reader_pkg::*;
#(
  parameter int DW = D0_DATA_WIDTH,
  parameter int AW = D0_BUF_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] head,
  output logic [AW:0]   occ
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_occ;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_occ == (AW+1)'(DEPTH));
  assign w_empty   = (r_occ == '0);
  assign w_do_pop  = pop && !w_empty;
  // A push into a full buffer is only accepted when a pop frees a slot this edge.
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign valid = !w_empty;
  assign head  = w_empty ? '0 : r_mem[r_rptr];
  assign occ   = r_occ;

endmodule

// File: rtl/d0_fifo_reader.sv
// Read-side controller for the D0 transmit FIFO: issues legal reads, absorbs
// the 1-cycle read latency and forwards words over a valid/ready handshake.
module d0_fifo_reader
  import d0_fifo_reader_pkg::*;
#(
  parameter int DW = D0_DATA_WIDTH,
  parameter int AW = D0_BUF_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            reset_L,
  d0_fifo_reader_if.master bus
);

  localparam int DEPTH = 1 << AW;

  d0_state_t     r_state;
  d0_state_t     w_state_nxt;
  logic          r_inflight;
  logic          r_error;
  logic [7:0]    r_word_cnt;
  logic          w_rd_en;
  logic          w_pop;
  logic          w_valid;
  logic          w_overflow;
  logic [DW-1:0] w_head;
  logic [AW:0]   w_occ;
  logic [AW+1:0] w_committed;

  // Slots already claimed: buffered words plus the read whose data is on its way.
  assign w_committed = {1'b0, w_occ} + {{(AW+1){1'b0}}, r_inflight};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.enable) w_state_nxt = ST_FLUSH;
        w_rd_en = !bus.fifo_empty && !bus.pause &&
                  (w_committed < (AW+2)'(DEPTH));
      end
      ST_FLUSH: begin
        if (bus.enable)                        w_state_nxt = ST_RUN;
        else if (!r_inflight && (w_occ == '0)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_inflight <= 1'b0;
      r_error    <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (bus.fifo_error || w_overflow) r_error <= 1'b1;
      if (w_pop) r_word_cnt <= r_word_cnt + 8'd1;
    end
  end

  assign w_pop      = w_valid && bus.ready_in;
  assign w_overflow = r_inflight && (w_occ == (AW+1)'(DEPTH)) && !w_pop;

  // fifo_data_out is only meaningful in the cycle after a read; its idle zeros are never captured.
  d0_reader_buf #(
    .DW (DW),
    .AW (AW)
  ) u_buf (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (r_inflight),
    .push_data (bus.fifo_data_out),
    .pop       (w_pop),
    .valid     (w_valid),
    .head      (w_head),
    .occ       (w_occ)
  );

  assign bus.fifo_rd_enable = w_rd_en;
  assign bus.valid_out      = w_valid;
  assign bus.data_out       = w_head;
  assign bus.busy           = (r_state != ST_IDLE) || r_inflight || (w_occ != '0);
  assign bus.error_out      = r_error;
  assign bus.word_cnt       = r_word_cnt;
  assign bus.state          = r_state;

endmodule

// File: doc/d0_fifo_reader.md
Name: d0_fifo_reader

Overview:
- Read-side controller for the D0 transmit FIFO (6-bit words, 4 entries).
- Issues rd_enable only when legal.
- Absorbs the FIFO's 1-cycle read latency and the fact that the FIFO drives zero on idle cycles.
- Forwards words to the next transmit stage over a valid/ready handshake, with an internal 4-entry output buffer and downstream pause support.

Parameters:
- data_width, 6, FIFO word width.
- buf_addr_width, 2, output buffer address width; buffer depth buf_depth = 2**buf_addr_width = 4.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset_L  input  1  reset, asynchronous, active-low.
- enable  input  1  1 = drain FIFO; 0 = stop issuing reads and flush.
- fifo_empty  input  1  empty flag from the FIFO.
- fifo_error  input  1  error flag from the FIFO.
- fifo_data_out  input  data_width  FIFO read data, valid the cycle after rd_enable.
- fifo_rd_enable  output  1  read strobe to the FIFO.
- pause  input  1  downstream almost-full; inhibits new reads only.
- ready_in  input  1  downstream accepts data_out this cycle.
- valid_out  output  1  data_out holds a word.
- data_out  output  data_width  buffer head word; 0 when valid_out = 0.
- busy  output  1  state != IDLE, or a read is in flight, or the buffer is non-empty.
- error_out  output  1  sticky error flag.
- word_cnt  output  8  words delivered (valid_out & ready_in), wraps 255 -> 0.

Behaviour:
- Reset (reset_L = 0, asynchronous): all of the following take effect immediately, independent of clk.
  - state = IDLE.
  - fifo_rd_enable = 0, valid_out = 0, data_out = 0, busy = 0, error_out = 0, word_cnt = 0.
  - Buffer pointers, occupancy count occ, and in-flight flag inflight all 0.
  - Reset mid-operation discards buffered and in-flight words; the FIFO is reset by the same reset_L.
- State machine:
  - IDLE -> RUN when enable = 1.
  - RUN -> FLUSH when enable = 0.
  - FLUSH -> IDLE when inflight = 0 and occ = 0.
  - FLUSH -> RUN when enable = 1 again.
- Read issue (combinational, from registered state only; no path from ready_in):
  - fifo_rd_enable = (state == RUN) & !fifo_empty & !pause & (occ + inflight < buf_depth).
- Latency:
  - fifo_rd_enable = 1 in cycle N sets inflight = 1 for cycle N+1.
  - fifo_data_out is captured into the buffer at the end of cycle N+1.
  - With an empty buffer, valid_out = 1 in cycle N+2.
- Back-to-back reads sustain 1 word/cycle while ready_in = 1 and pause = 0.
- Capture rule: capture happens only when inflight = 1. fifo_data_out is ignored in every other cycle, including the FIFO's zero output.
- Handshake:
  - A word leaves the buffer on a clock edge where valid_out & ready_in.
  - data_out and valid_out stay stable while ready_in = 0.
  - Capture and pop in the same cycle leave occ unchanged.
  - Pointers wrap modulo buf_depth.
- Pause:
  - Blocks new reads only.
  - An in-flight word is always captured.
  - Buffered words still drain if ready_in = 1.
- Enable drop: any in-flight read is completed and captured. Buffered words are delivered before entering IDLE; none are dropped.
- error_out is set and held until reset on either condition:
  - fifo_error = 1 in any cycle.
  - A capture with occ == buf_depth and no simultaneous pop (must be unreachable).
- word_cnt increments by 1 on each valid_out & ready_in edge; 8-bit wrap.
- occ is buf_addr_width+1 bits wide and never exceeds buf_depth.

Decomposition:
- Shared package holds:
  - State encodings: IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2.
  - Default data_width (6).
  - Default buf_addr_width (2).
- One sub-module, d0_reader_buf: the output buffer.
  - Contents: write/read pointers, occ, storage, valid_out/data_out generation.
  - Ports: clk, reset_L, push, push_data, pop, valid, head, occ.
- The top holds: FSM, read issue, inflight tracking, error and word_cnt.

Test Plan:
- Reset then enable = 1 with FIFO holding 3, 5, 7, ready_in = 1 -> fifo_rd_enable high for cycles 1-3 after RUN. valid_out high cycles 3-5 with data_out 3, 5, 7. word_cnt = 3; then busy = 0 after enable = 0.
- FIFO holding 6 words, ready_in = 0 -> exactly 4 reads issued, then fifo_rd_enable = 0. valid_out = 1 with first word held stable. Raising ready_in delivers all 6 in order with no duplicates or zeros.
- pause = 1 in the same cycle a read is in flight -> that word is still captured and delivered. No further reads until pause = 0.
- enable = 0 with 2 buffered words and 1 in flight -> state FLUSH, 3 words delivered, then IDLE, busy = 0. No reads issued during FLUSH.
- fifo_error pulse for one cycle -> error_out = 1 and held across later traffic until reset_L = 0.
- Assert reset_L = 0 asynchronously mid-transfer -> valid_out, fifo_rd_enable, word_cnt = 0 immediately. After release the next word delivered is the first word written after reset.
